// File: rtl/seg7_pkg.sv
// Seven-segment pattern constants and BCD encoder shared by the display counter.
// Bit order is {a,b,c,d,e,f,g,dp}, active-high; the decimal point is never lit.
package seg7_pkg;

  localparam logic [7:0] SEG_0     = 8'b1111_1100;
  localparam logic [7:0] SEG_1     = 8'b0110_0000;
  localparam logic [7:0] SEG_2     = 8'b1101_1010;
  localparam logic [7:0] SEG_3     = 8'b1111_0010;
  localparam logic [7:0] SEG_4     = 8'b0110_0110;
  localparam logic [7:0] SEG_5     = 8'b1011_0110;
  localparam logic [7:0] SEG_6     = 8'b1011_1110;
  localparam logic [7:0] SEG_7     = 8'b1110_0000;
  localparam logic [7:0] SEG_8     = 8'b1111_1110;
  localparam logic [7:0] SEG_9     = 8'b1111_0110;
  localparam logic [7:0] SEG_BLANK = 8'b0000_0000;

  // Non-decimal codes map to blank; the counter never produces them.
  function automatic logic [7:0] seg7_encode(input logic [3:0] bcd);
    logic [7:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decoder with a blanking override.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  // Blanking wins over the digit value.
  always_comb begin
    o_seg = i_blank ? SEG_BLANK : seg7_encode(i_bcd);
  end

endmodule

// File: rtl/seg7_bcd_counter_mux.sv
// Multi-digit BCD up/down counter with round-robin seven-segment scan.
// A prescaler generates the count tick; a separate free-running scan counter
// walks the digit index. Segment and digit-select outputs are registered
// together from the same index so they can never disagree.
module seg7_bcd_counter_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 27_000_000,
  parameter int SCAN_DIV = 6_750,
  parameter int LZB      = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_up,
  input  logic                  i_clr,
  output logic [7:0]            o_seg,
  output logic [DIGITS-1:0]     o_dig,
  output logic [4*DIGITS-1:0]   o_count,
  output logic                  o_wrap
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW     = 4 * DIGITS;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [CW-1:0]     count_q, count_d;
  logic              wrap_q, wrap_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] dig_q, dig_d;

  logic              tick;
  logic [CW-1:0]     step;
  logic              carry;
  logic              all9;
  logic              all0;
  logic [3:0]        cur_digit;
  logic              scan_wrap;
  logic              higher_zero;
  logic [DIGITS-1:0] blank_vec;
  logic [3:0]        sel_digit;
  logic              sel_blank;

  // Prescaler: tick on the terminal count, clear has priority, frozen while disabled.
  always_comb begin
    tick  = i_en && (pre_q == PRE_W'(TICK_DIV - 1));
    pre_d = pre_q;
    if (i_clr)     pre_d = '0;
    else if (tick) pre_d = '0;
    else if (i_en) pre_d = pre_q + 1'b1;
  end

  // Ripple carry/borrow through the decimal digits; each digit stays in 0..9.
  always_comb begin
    step      = count_q;
    carry     = 1'b1;
    all9      = 1'b1;
    all0      = 1'b1;
    cur_digit = '0;
    for (int k = 0; k < DIGITS; k++) begin
      cur_digit = count_q[4*k +: 4];
      if (cur_digit != 4'd9) all9 = 1'b0;
      if (cur_digit != 4'd0) all0 = 1'b0;
      if (carry) begin
        if (i_up) begin
          if (cur_digit == 4'd9) begin
            step[4*k +: 4] = 4'd0;
          end else begin
            step[4*k +: 4] = cur_digit + 4'd1;
            carry          = 1'b0;
          end
        end else begin
          if (cur_digit == 4'd0) begin
            step[4*k +: 4] = 4'd9;
          end else begin
            step[4*k +: 4] = cur_digit - 4'd1;
            carry          = 1'b0;
          end
        end
      end
    end
  end

  // Count register update and wrap pulse; clear overrides a coincident tick.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (i_clr) begin
      count_d = '0;
    end else if (tick) begin
      count_d = step;
      wrap_d  = i_up ? all9 : all0;
    end
  end

  // Free-running scan divider advancing the digit index round-robin.
  always_comb begin
    scan_wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));
    scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
    idx_d     = idx_q;
    if (scan_wrap) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Leading-zero detection from the top digit down, then select the scanned digit.
  always_comb begin
    higher_zero = 1'b1;
    blank_vec   = '0;
    sel_digit   = '0;
    sel_blank   = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      higher_zero  = higher_zero && (count_q[4*k +: 4] == 4'd0);
      blank_vec[k] = (LZB != 0) && (k != 0) && higher_zero;
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_digit = count_q[4*k +: 4];
        sel_blank = blank_vec[k];
      end
    end
    dig_d = ~(DIGITS'(1) << idx_q);
  end

  seg7_decode u_decode (
    .i_bcd   (sel_digit),
    .i_blank (sel_blank),
    .o_seg   (seg_d)
  );

  // All state and outputs registered; asynchronous reset to the idle display of 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pre_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_0;
      dig_q   <= ~DIGITS'(1);
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign o_seg   = seg_q;
  assign o_dig   = dig_q;
  assign o_count = count_q;
  assign o_wrap  = wrap_q;

endmodule

// File: doc/seg7_bcd_counter_mux.md
# seg7_bcd_counter_mux

Parametrised multi-digit BCD up/down counter with time-multiplexed 7-segment drive. It is the next generation of the single-digit 0–9 display counter: N decimal digits, selectable direction, enable/clear controls, leading-zero blanking and a round-robin digit scan. It sits directly behind the board's 7-segment header, clocked by the 27 MHz board clock.

## Interface
- DIGITS, 4: number of BCD digits/display positions (1–8)
- TICK_DIV, 27_000_000: clock cycles per count step (≥2)
- SCAN_DIV, 6_750: clock cycles each digit stays lit (≥2)
- LZB, 1: 1 = blank leading zeros; 0 = show all digits
- i_clk  in  1  system clock, 27 MHz
- i_rst  in  1  reset, asynchronous, active-high
- i_en  in  1  count enable; prescaler and count frozen while low
- i_up  in  1  direction: 1 = up, 0 = down, sampled at each tick
- i_clr  in  1  synchronous clear of count and prescaler
- o_seg  out  8  segments {a,b,c,d,e,f,g,dp}, active-high, dp always 0
- o_dig  out  DIGITS  digit select, one-hot active-low, bit 0 = least-significant digit
- o_count  out  4*DIGITS  current BCD value, digit k at [4k+3:4k]
- o_wrap  out  1  one-cycle pulse on wrap (all-9s→0 up, 0→all-9s down)

## Operation
- Prescaler counts 0..TICK_DIV-1 while i_en=1; tick asserted on the cycle it equals TICK_DIV-1, after which it returns to 0.
- On tick: BCD value steps by one in direction i_up; per-digit carry/borrow chain, each digit 0..9 only (values 10–15 never occur).
- Up from all-9s → all-0, o_wrap=1 next cycle. Down from all-0 → all-9s, o_wrap=1.
- i_clr: count←0, prescaler←0, o_wrap←0; priority over tick in the same cycle. Scan unaffected.
- i_en=0: prescaler and count hold; scan continues.
- Scan counter 0..SCAN_DIV-1 free-runs; at SCAN_DIV-1 digit index advances 0→1→…→DIGITS-1→0.
- Segment patterns: 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110, 5=10110110, 6=10111110, 7=11100000, 8=11111110, 9=11110110.
- Blanking (LZB=1): digit k>0 shows 00000000 when it and all higher digits are 0; digit 0 always shown.
- DIGITS=1: o_dig constantly 1'b0; scan counter may be omitted.

## Timing
- Reset values: count 0, prescaler 0, scan counter 0, digit index 0, o_dig = ~1 (only bit 0 low), o_seg=11111100, o_wrap=0.
- o_count, o_wrap, o_seg, o_dig all registered.
- o_count updates the cycle after the tick cycle; o_wrap high in that same cycle only.
- o_seg and o_dig change together, one cycle after the scan index changes or the selected digit's value changes; never a cycle where o_seg belongs to a different digit than o_dig.
- First count step occurs TICK_DIV cycles after reset release with i_en=1.
- Direction change mid-period takes effect at next tick; prescaler not restarted.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

## Structure
- Package seg7_pkg: 7-segment pattern constants for 0–9 and blank, SEG_BLANK, and a function seg7_encode(bcd)→8-bit pattern.
- Sub-module seg7_decode: combinational BCD→segment using seg7_pkg; instantiated once on the muxed digit.
- Top holds prescaler, BCD chain, scan counter, blanking logic, output registers.

## Test plan
- Reset: DIGITS=4, TICK_DIV=4, SCAN_DIV=3; hold i_rst → o_count=0, o_dig=1110, o_seg=11111100, o_wrap=0.
- Up count with carry: i_en=1, i_up=1 from 0x0009 → after one tick o_count=0x0010, digit1 shows 01100000; at 0x9999 next tick → 0x0000 and o_wrap high exactly 1 cycle.
- Down wrap: i_up=0 from 0x0000 → 0x9999, o_wrap pulse; then 0x9998.
- Clear/enable priority: i_clr and tick same cycle → o_count=0, no wrap; i_en=0 for 20 cycles → o_count unchanged, scan continues.
- Scan and blanking: value 0x0042, LZB=1 → o_dig sequence 1110,1101,1011,0111 each 3 cycles; segs 01100110(2? no: digit0=2→11011010), digit1=4→01100110, digits2–3 → 00000000; LZB=0 → digits2–3 show 11111100.
- Async reset mid-count at 0x0137 → all outputs at reset values in the same cycle, counting restarts from 0.
